// File: rtl/bldc_pkg.sv
// rtl/bldc_pkg.sv - shared types and helpers for the BLDC open-loop start-up sequencer
package bldc_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ALIGN,
        ST_RAMP,
        ST_DONE
    } rampup_state_e;

    typedef logic [2:0] step_t;

    localparam step_t STEP_LAST = 3'd5;

    // Unsigned add with saturation; the 17-bit sum cannot wrap before the compare.
    function automatic logic [15:0] sat_add16(input logic [15:0] a,
                                              input logic [15:0] b,
                                              input logic [15:0] max);
        logic [16:0] sum;
        sum = {1'b0, a} + {1'b0, b};
        if (sum > {1'b0, max}) begin
            return max;
        end
        return sum[15:0];
    endfunction

endpackage

// File: rtl/bldc_comm_timer.sv
// rtl/bldc_comm_timer.sv - commutation interval timer with six-step wrap counter
module bldc_comm_timer
    import bldc_pkg::*;
#(
    parameter int PW = 24
) (
    input  logic          clk_i,
    input  logic          rst_ni,
    input  logic          ena_i,
    input  logic          restart_i,
    input  logic [PW-1:0] limit_i,
    output logic          wrap_o,
    output logic          tick_o,
    output step_t         step_o
);

    localparam logic [PW-1:0] ONE = PW'(1);

    logic [PW-1:0] cnt_q, cnt_d;
    logic          tick_q, tick_d;
    step_t         step_q, step_d;

    // wrap_o is the combinational "commutate at this edge" used by the sequencer
    always_comb begin
        wrap_o = ena_i && !restart_i && (cnt_q == limit_i - ONE);
        cnt_d  = cnt_q;
        step_d = step_q;
        tick_d = wrap_o;
        if (restart_i) begin
            cnt_d  = '0;
            step_d = '0;
        end else if (ena_i) begin
            if (wrap_o) begin
                cnt_d  = '0;
                step_d = (step_q == STEP_LAST) ? step_t'(0) : step_q + 3'd1;
            end else begin
                cnt_d = cnt_q + ONE;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q  <= '0;
            tick_q <= 1'b0;
            step_q <= '0;
        end else begin
            cnt_q  <= cnt_d;
            tick_q <= tick_d;
            step_q <= step_d;
        end
    end

    assign tick_o = tick_q;
    assign step_o = step_q;

endmodule

// File: rtl/bldc_rampup_seq.sv
// rtl/bldc_rampup_seq.sv - BLDC open-loop start-up: rotor alignment then accelerating six-step ramp
module bldc_rampup_seq
    import bldc_pkg::*;
#(
    parameter int          PW             = 24,
    parameter int          ALIGN_CYCLES   = 10,
    parameter logic [15:0] ALIGN_DUTY     = 16'd64,
    parameter int          START_PERIOD   = 20,
    parameter int          END_PERIOD     = 8,
    parameter int          PERIOD_DEC     = 4,
    parameter int          COMMS_PER_STEP = 2,
    parameter logic [15:0] START_DUTY     = 16'd100,
    parameter logic [15:0] DUTY_INC       = 16'd50,
    parameter logic [15:0] DUTY_MAX       = 16'd1000
) (
    input  logic          clk_i,
    input  logic          rst_ni,
    input  logic          start_i,
    input  logic          abort_i,
    output logic [PW-1:0] period_o,
    output logic          comm_tick_o,
    output logic [2:0]    step_o,
    output logic [15:0]   duty_o,
    output logic          busy_o,
    output logic          done_o
);

    localparam logic [PW-1:0] ONE        = PW'(1);
    localparam logic [PW-1:0] ALIGN_LAST = PW'(ALIGN_CYCLES - 1);
    localparam logic [PW-1:0] START_P    = PW'(START_PERIOD);
    localparam logic [PW-1:0] END_P      = PW'(END_PERIOD);
    localparam logic [PW-1:0] DEC_P      = PW'(PERIOD_DEC);
    localparam logic [15:0]   CPS_LAST   = 16'(COMMS_PER_STEP - 1);

    rampup_state_e state_q, state_d;
    logic [PW-1:0] align_cnt_q, align_cnt_d;
    logic [PW-1:0] period_q, period_d;
    logic [15:0]   duty_q, duty_d;
    logic [15:0]   comm_cnt_q, comm_cnt_d;
    logic          busy_q, busy_d;
    logic          done_q, done_d;

    logic  go_idle;
    logic  timer_ena;
    logic  timer_restart;
    logic  wrap;
    logic  tick;
    step_t step;

    always_comb begin
        go_idle       = abort_i || !start_i;
        timer_ena     = (state_q == ST_RAMP) || (state_q == ST_DONE);
        timer_restart = go_idle || !timer_ena;

        state_d     = state_q;
        align_cnt_d = align_cnt_q;
        period_d    = period_q;
        duty_d      = duty_q;
        comm_cnt_d  = comm_cnt_q;
        busy_d      = busy_q;
        done_d      = done_q;

        case (state_q)
            ST_IDLE: begin
                if (start_i && !abort_i) begin
                    state_d     = ST_ALIGN;
                    align_cnt_d = '0;
                    duty_d      = ALIGN_DUTY;
                    busy_d      = 1'b1;
                end
            end
            ST_ALIGN: begin
                if (align_cnt_q == ALIGN_LAST) begin
                    state_d    = ST_RAMP;
                    period_d   = START_P;
                    duty_d     = START_DUTY;
                    comm_cnt_d = '0;
                end else begin
                    align_cnt_d = align_cnt_q + ONE;
                end
            end
            ST_RAMP: begin
                if (wrap) begin
                    if (comm_cnt_q == CPS_LAST) begin
                        comm_cnt_d = '0;
                        duty_d     = sat_add16(duty_q, DUTY_INC, DUTY_MAX);
                        // Compare before subtracting so a small period never underflows
                        if (period_q <= END_P + DEC_P) begin
                            period_d = END_P;
                            state_d  = ST_DONE;
                            done_d   = 1'b1;
                        end else begin
                            period_d = period_q - DEC_P;
                        end
                    end else begin
                        comm_cnt_d = comm_cnt_q + 16'd1;
                    end
                end
            end
            ST_DONE: begin
            end
            default: state_d = ST_IDLE;
        endcase

        if (go_idle) begin
            state_d     = ST_IDLE;
            align_cnt_d = '0;
            period_d    = '0;
            duty_d      = '0;
            comm_cnt_d  = '0;
            busy_d      = 1'b0;
            done_d      = 1'b0;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= ST_IDLE;
            align_cnt_q <= '0;
            period_q    <= '0;
            duty_q      <= '0;
            comm_cnt_q  <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            align_cnt_q <= align_cnt_d;
            period_q    <= period_d;
            duty_q      <= duty_d;
            comm_cnt_q  <= comm_cnt_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
        end
    end

    bldc_comm_timer #(
        .PW(PW)
    ) u_timer (
        .clk_i    (clk_i),
        .rst_ni   (rst_ni),
        .ena_i    (timer_ena),
        .restart_i(timer_restart),
        .limit_i  (period_q),
        .wrap_o   (wrap),
        .tick_o   (tick),
        .step_o   (step)
    );

    assign period_o    = period_q;
    assign comm_tick_o = tick;
    assign step_o      = step;
    assign duty_o      = duty_q;
    assign busy_o      = busy_q;
    assign done_o      = done_q;

endmodule

// File: tb/tb_bldc_rampup_seq.sv
// tb/tb_bldc_rampup_seq.sv - self-checking bench for bldc_rampup_seq (default, DUTY_MAX=120, END_PERIOD=20)
module tb_bldc_rampup_seq;

    localparam int PW = 24;

    logic clk = 1'b0;
    logic rst_ni = 1'b0;
    logic start_i = 1'b0;
    logic abort_i = 1'b0;

    always #5 clk = ~clk;

    logic [PW-1:0] a_period, b_period, c_period;
    logic          a_tick, b_tick, c_tick;
    logic [2:0]    a_step, b_step, c_step;
    logic [15:0]   a_duty, b_duty, c_duty;
    logic          a_busy, b_busy, c_busy;
    logic          a_done, b_done, c_done;

    bldc_rampup_seq u_dut (
        .clk_i(clk), .rst_ni(rst_ni), .start_i(start_i), .abort_i(abort_i),
        .period_o(a_period), .comm_tick_o(a_tick), .step_o(a_step),
        .duty_o(a_duty), .busy_o(a_busy), .done_o(a_done)
    );

    bldc_rampup_seq #(.DUTY_MAX(16'd120)) u_dmax (
        .clk_i(clk), .rst_ni(rst_ni), .start_i(start_i), .abort_i(abort_i),
        .period_o(b_period), .comm_tick_o(b_tick), .step_o(b_step),
        .duty_o(b_duty), .busy_o(b_busy), .done_o(b_done)
    );

    bldc_rampup_seq #(.END_PERIOD(20)) u_endp (
        .clk_i(clk), .rst_ni(rst_ni), .start_i(start_i), .abort_i(abort_i),
        .period_o(c_period), .comm_tick_o(c_tick), .step_o(c_step),
        .duty_o(c_duty), .busy_o(c_busy), .done_o(c_done)
    );

    typedef struct {
        int period;
        int tick;
        int step;
        int duty;
        int busy;
        int done;
    } exp_t;

    int total = 0;
    int bad = 0;

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
        end
    endtask

    // Expected outputs k cycles after ALIGN entry, derived from the tick schedule
    function automatic exp_t model(input int k, input int end_p, input int dmax);
        exp_t e;
        int r, t, per, duty, comms, step, dn;
        e.period = 0; e.tick = 0; e.step = 0; e.duty = 64; e.busy = 1; e.done = 0;
        if (k < 10) return e;
        r = k - 10; t = 0; per = 20; duty = 100; comms = 0; step = 0; dn = 0;
        while (t + per <= r) begin
            t = t + per;
            step = (step + 1) % 6;
            if (dn == 0) begin
                comms++;
                if (comms == 2) begin
                    comms = 0;
                    duty = (duty + 50 > dmax) ? dmax : duty + 50;
                    if (per <= end_p + 4) begin
                        per = end_p;
                        dn = 1;
                    end else begin
                        per = per - 4;
                    end
                end
            end
        end
        e.period = per;
        e.tick = (r == t && t > 0) ? 1 : 0;
        e.step = step;
        e.duty = duty;
        e.done = dn;
        return e;
    endfunction

    logic act_m = 1'b0;
    int   k_m = 0;

    always @(posedge clk or negedge rst_ni) begin
        if (!rst_ni) begin
            act_m <= 1'b0;
            k_m   <= 0;
        end else if (act_m) begin
            if (abort_i || !start_i) act_m <= 1'b0;
            else k_m <= k_m + 1;
        end else if (start_i && !abort_i) begin
            act_m <= 1'b1;
            k_m   <= 0;
        end
    end

    task automatic cmp_dut(input string tag, input exp_t e, input int per, input int tk,
                           input int st, input int du, input int bu, input int dn);
        check({tag, "_period"}, per, e.period);
        check({tag, "_tick"}, tk, e.tick);
        check({tag, "_step"}, st, e.step);
        check({tag, "_duty"}, du, e.duty);
        check({tag, "_busy"}, bu, e.busy);
        check({tag, "_done"}, dn, e.done);
    endtask

    always @(negedge clk) begin
        exp_t ea, eb, ec;
        if (act_m) begin
            ea = model(k_m, 8, 1000);
            eb = model(k_m, 8, 120);
            ec = model(k_m, 20, 1000);
        end else begin
            ea = '{0, 0, 0, 0, 0, 0};
            eb = ea;
            ec = ea;
        end
        cmp_dut("def", ea, int'(a_period), int'(a_tick), int'(a_step), int'(a_duty), int'(a_busy), int'(a_done));
        cmp_dut("dmax", eb, int'(b_period), int'(b_tick), int'(b_step), int'(b_duty), int'(b_busy), int'(b_done));
        cmp_dut("endp", ec, int'(c_period), int'(c_tick), int'(c_step), int'(c_duty), int'(c_busy), int'(c_done));
    end

    task automatic wait_k(input int n);
        bit hit;
        hit = 1'b0;
        for (int i = 0; i < 2000 && !hit; i++) begin
            @(negedge clk);
            if (act_m && k_m == n) hit = 1'b1;
        end
        if (!hit) check($sformatf("wait_k%0d_timeout", n), 0, 1);
    endtask

    initial begin
        exp_t m;
        m = model(10, 8, 1000);
        check("pin_ramp_entry_period", m.period, 20);
        check("pin_ramp_entry_duty", m.duty, 100);
        m = model(50, 8, 1000);
        check("pin_k50_period", m.period, 16);
        check("pin_k50_step", m.step, 2);
        m = model(105, 8, 1000);
        check("pin_k105_done", m.done, 0);
        m = model(106, 8, 1000);
        check("pin_k106_done", m.done, 1);
        check("pin_k106_duty", m.duty, 250);
        m = model(82, 8, 120);
        check("pin_dmax_duty", m.duty, 120);
        m = model(50, 20, 1000);
        check("pin_endp_done", m.done, 1);

        repeat (3) @(posedge clk);
        #1 rst_ni = 1'b1;
        @(negedge clk);
        check("rst_period", int'(a_period), 0);
        check("rst_busy", int'(a_busy), 0);
        check("rst_duty", int'(a_duty), 0);

        start_i = 1'b1;
        wait_k(0);
        check("align_busy", int'(a_busy), 1);
        check("align_duty", int'(a_duty), 64);
        wait_k(10);
        check("ramp_period", int'(a_period), 20);
        check("ramp_duty", int'(a_duty), 100);
        wait_k(30);
        check("first_tick", int'(a_tick), 1);
        check("first_step", int'(a_step), 1);
        wait_k(50);
        check("endp_done", int'(c_done), 1);
        check("endp_duty", int'(c_duty), 150);
        check("dmax_duty", int'(b_duty), 120);
        wait_k(105);
        check("done_early", int'(a_done), 0);
        wait_k(106);
        check("done_rise", int'(a_done), 1);
        check("done_tick", int'(a_tick), 1);
        check("done_period", int'(a_period), 8);
        check("done_duty", int'(a_duty), 250);
        wait_k(154);
        check("done_wrap_step", int'(a_step), 0);
        check("done_wrap_tick", int'(a_tick), 1);
        wait_k(160);
        start_i = 1'b0;
        repeat (3) @(negedge clk);

        start_i = 1'b1;
        wait_k(29);
        abort_i = 1'b1;
        @(posedge clk);
        #1 abort_i = 1'b0;
        start_i = 1'b0;
        @(negedge clk);
        check("abort_step", int'(a_step), 0);
        check("abort_tick", int'(a_tick), 0);
        check("abort_busy", int'(a_busy), 0);
        check("abort_period", int'(a_period), 0);
        repeat (2) @(negedge clk);

        start_i = 1'b1;
        wait_k(40);
        #2 rst_ni = 1'b0;
        #1;
        check("arst_busy", int'(a_busy), 0);
        check("arst_period", int'(a_period), 0);
        check("arst_duty", int'(a_duty), 0);
        check("arst_step", int'(a_step), 0);
        start_i = 1'b0;
        @(posedge clk);
        #2 rst_ni = 1'b1;
        #1;
        check("post_rst_busy", int'(a_busy), 0);
        start_i = 1'b1;
        wait_k(12);
        start_i = 1'b0;
        repeat (3) @(negedge clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
